// File: rtl/decode_issue_pkg.sv
// Shared decode definitions: opcodes, instruction IDs, field positions
// and the issued-bundle layout. Used by decode_issue and alu_top.
package decode_issue_pkg;

  localparam int XLEN = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 25;

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000,
    OP_SUBI = 6'b000001,
    OP_AND  = 6'b000011,
    OP_ORI  = 6'b000110,
    OP_LW   = 6'b001000,
    OP_SW   = 6'b001001,
    OP_J    = 6'b010000,
    OP_SLT  = 6'b010011
  } opcode_e;

  localparam logic [XLEN-1:0] ID_ILL  = 32'd0;
  localparam logic [XLEN-1:0] ID_ADD  = 32'd1;
  localparam logic [XLEN-1:0] ID_SUBI = 32'd2;
  localparam logic [XLEN-1:0] ID_AND  = 32'd7;
  localparam logic [XLEN-1:0] ID_ORI  = 32'd10;
  localparam logic [XLEN-1:0] ID_LW   = 32'd13;
  localparam logic [XLEN-1:0] ID_SW   = 32'd14;
  localparam logic [XLEN-1:0] ID_J    = 32'd21;
  localparam logic [XLEN-1:0] ID_SLT  = 32'd24;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] id;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] sd;
    logic [4:0]      dest;
    logic            wr_en;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/decode_issue_reg_file.sv
// 32x32 register file, two read ports, one write port, write bypass.
// Ports: clk, reset, ra1/rd1, ra2/rd2 reads; we/wa/wd write. x0 reads 0.
module reg_file
  import decode_issue_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_q [32];
  logic [XLEN-1:0] mem_d [32];

  always_comb begin
    mem_d = mem_q;
    if (we && wa != 5'd0) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Bypass lets decode see a writeback landing this cycle.
  always_comb begin
    rd1 = mem_q[ra1];
    rd2 = mem_q[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes in_ir, reads operands, tracks pending writes
// and issues a registered bundle over a valid/ready handshake.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ir,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ir,
  output logic [31:0] ID,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [31:0] sd,
  output logic [4:0]  dest,
  output logic        wr_en,
  output logic        illegal
);

  logic [4:0]  rs_f, rt_f, rd_f;
  logic [15:0] imm;
  logic [31:0] sext, zext;
  logic [31:0] rf_rd1, rf_rd2;
  logic        rs_use, rt_use;
  issue_t      dec;

  logic [31:0] pending_q, pending_d;
  logic [31:0] clr_v, live;
  logic        hazard, accept;
  logic        out_valid_q, out_valid_d;
  issue_t      out_q, out_d;

  assign rs_f = in_ir[RS_HI:RS_LO];
  assign rt_f = in_ir[RT_HI:RT_LO];
  assign rd_f = in_ir[RD_HI:RD_LO];
  assign imm  = in_ir[IMM_HI:IMM_LO];
  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'b0, imm};

  reg_file u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs_f),
    .rd1   (rf_rd1),
    .ra2   (rt_f),
    .rd2   (rf_rd2),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  always_comb begin
    dec    = '0;
    dec.ir = in_ir;
    dec.rs = rf_rd1;
    rs_use = 1'b1;
    rt_use = 1'b0;
    case (opcode_e'(in_ir[OP_HI:OP_LO]))
      OP_ADD, OP_AND, OP_SLT: begin
        dec.id    = (in_ir[OP_HI:OP_LO] == OP_ADD) ? ID_ADD :
                    (in_ir[OP_HI:OP_LO] == OP_AND) ? ID_AND : ID_SLT;
        dec.rt    = rf_rd2;
        dec.dest  = rd_f;
        dec.wr_en = 1'b1;
        rt_use    = 1'b1;
      end
      OP_SUBI, OP_LW: begin
        dec.id    = (in_ir[OP_HI:OP_LO] == OP_SUBI) ? ID_SUBI : ID_LW;
        dec.rt    = sext;
        dec.dest  = rt_f;
        dec.wr_en = 1'b1;
      end
      OP_ORI: begin
        dec.id    = ID_ORI;
        dec.rt    = zext;
        dec.dest  = rt_f;
        dec.wr_en = 1'b1;
      end
      OP_SW: begin
        dec.id = ID_SW;
        dec.rt = sext;
        dec.sd = rf_rd2;
        rt_use = 1'b1;
      end
      OP_J: begin
        dec.id = ID_J;
        dec.rs = '0;
        dec.rt = {6'b0, in_ir[JT_HI:0]};
        rs_use = 1'b0;
      end
      default: begin
        dec.id      = ID_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.dest == 5'd0) dec.wr_en = 1'b0;
  end

  // A bit being cleared by this cycle's writeback no longer blocks.
  always_comb begin
    clr_v = wb_en ? (32'd1 << wb_addr) : 32'd0;
    live  = pending_q & ~clr_v;
    hazard = in_valid &&
             ((rs_use && live[rs_f]) ||
              (rt_use && live[rt_f]) ||
              (dec.wr_en && live[dec.dest]));
  end

  assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    pending_d   = pending_q & ~clr_v;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (accept && dec.wr_en) pending_d[dec.dest] = 1'b1;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ir        = out_q.ir;
  assign ID        = out_q.id;
  assign rs        = out_q.rs;
  assign rt        = out_q.rt;
  assign sd        = out_q.sd;
  assign dest      = out_q.dest;
  assign wr_en     = out_q.wr_en;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus random traffic,
// checked each cycle against a register/scoreboard model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_ir, wb_data, ir, ID, rs, rt, sd;
  logic [4:0]  wb_addr, dest;
  logic        wr_en, illegal;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ir(ir), .ID(ID),
    .rs(rs), .rt(rt), .sd(sd), .dest(dest), .wr_en(wr_en),
    .illegal(illegal)
  );

  typedef struct {
    logic        v;
    logic [31:0] ir, id, rs, rt, sd;
    logic [4:0]  dest;
    logic        wr, ill;
  } bnd_t;

  bnd_t        m;
  logic [31:0] mrf [32];
  logic [31:0] mpend;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  function automatic logic mbusy(input logic [4:0] a);
    return mpend[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic void mdec(input logic [31:0] x, output bnd_t b,
                               output logic haz);
    int   id;
    logic rtype, itype;
    case (x[31:26])
      6'd0:    id = 1;
      6'd1:    id = 2;
      6'd3:    id = 7;
      6'd6:    id = 10;
      6'd8:    id = 13;
      6'd9:    id = 14;
      6'd16:   id = 21;
      6'd19:   id = 24;
      default: id = 0;
    endcase
    rtype  = (id == 1 || id == 7 || id == 24);
    itype  = (id == 2 || id == 10 || id == 13);
    b.v    = 1'b1;
    b.ir   = x;
    b.id   = id;
    b.ill  = (id == 0);
    b.rs   = (id == 21) ? 32'd0 : mread(x[25:21]);
    if (rtype) b.rt = mread(x[20:16]);
    else if (id == 10) b.rt = {16'd0, x[15:0]};
    else if (id == 2 || id == 13 || id == 14)
      b.rt = {{16{x[15]}}, x[15:0]};
    else if (id == 21) b.rt = {6'd0, x[25:0]};
    else b.rt = 32'd0;
    b.sd   = (id == 14) ? mread(x[20:16]) : 32'd0;
    b.dest = rtype ? x[15:11] : itype ? x[20:16] : 5'd0;
    b.wr   = (rtype || itype) && b.dest != 5'd0;
    haz = in_valid &&
          ((id != 21 && mbusy(x[25:21])) ||
           ((rtype || id == 14) && mbusy(x[20:16])) ||
           (b.wr && mbusy(b.dest)));
  endfunction

  task automatic cycle(input logic rst, input logic iv,
                       input logic [31:0] x, input logic ordy,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, output logic got_rdy);
    bnd_t d;
    logic haz, rdy;
    reset = rst; in_valid = iv; in_ir = x; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    mdec(x, d, haz);
    rdy = !rst && (!m.v || ordy) && !haz;
    got_rdy = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (rst) begin
      m = '{default: '0};
      mpend = '0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else begin
      if (iv && rdy) m = d;
      else if (ordy) m.v = 1'b0;
      if (we) mpend[wa] = 1'b0;
      if (iv && rdy && d.wr) mpend[d.dest] = 1'b1;
      if (we && wa != 5'd0) mrf[wa] = wd;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m.v});
    if (m.v || rst) begin
      chk("ir", ir, m.ir);
      chk("id", ID, m.id);
      chk("rs", rs, m.rs);
      chk("rt", rt, m.rt);
      chk("sd", sd, m.sd);
      chk("dest", {27'd0, dest}, {27'd0, m.dest});
      chk("wr_en", {31'd0, wr_en}, {31'd0, m.wr});
      chk("illegal", {31'd0, illegal}, {31'd0, m.ill});
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op,
    input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] a, input logic [4:0] b, input logic [15:0] im);
    return {op, a, b, im};
  endfunction

  logic [31:0] x, held;
  logic [5:0]  ops [10];
  logic        g;

  initial begin
    m = '{default: '0};
    mpend = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    ops[0] = 6'd0;  ops[1] = 6'd1;  ops[2] = 6'd3;  ops[3] = 6'd6;
    ops[4] = 6'd8;  ops[5] = 6'd9;  ops[6] = 6'd16; ops[7] = 6'd19;
    ops[8] = 6'd63; ops[9] = 6'd2;

    cycle(1, 0, 0, 1, 0, 0, 0, g);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    cycle(0, 0, 0, 1, 1, 3, 10, g);
    cycle(0, 0, 0, 1, 1, 5, 12, g);
    cycle(0, 1, 32'h00653000, 1, 0, 0, 0, g);
    chk("add_id", ID, 1);
    chk("add_rs", rs, 10);
    chk("add_rt", rt, 12);
    chk("add_dest", {27'd0, dest}, 6);
    chk("add_wr", {31'd0, wr_en}, 1);

    cycle(0, 0, 0, 1, 1, 2, 10, g);
    cycle(0, 1, enc_i(6'd1, 2, 1, 16'hFFFF), 1, 0, 0, 0, g);
    chk("subi_id", ID, 2);
    chk("subi_rs", rs, 10);
    chk("subi_rt", rt, 32'hFFFFFFFF);
    cycle(0, 1, enc_i(6'd6, 2, 7, 16'hFFFF), 1, 0, 0, 0, g);
    chk("ori_id", ID, 10);
    chk("ori_rt", rt, 32'h0000FFFF);
    cycle(0, 0, 0, 1, 1, 6, 0, g);
    cycle(0, 0, 0, 1, 1, 1, 0, g);
    cycle(0, 0, 0, 1, 1, 7, 0, g);

    cycle(0, 1, enc_r(6'd0, 3, 5, 1), 1, 0, 0, 0, g);
    x = enc_r(6'd3, 1, 3, 4);
    cycle(0, 1, x, 1, 0, 0, 0, g);
    chk("raw_stall0", {31'd0, g}, 0);
    cycle(0, 1, x, 1, 0, 0, 0, g);
    chk("raw_stall1", {31'd0, g}, 0);
    cycle(0, 1, x, 1, 1, 1, 99, g);
    chk("raw_release", {31'd0, g}, 1);
    chk("raw_rs_bypass", rs, 99);
    chk("raw_id", ID, 7);
    cycle(0, 0, 0, 1, 1, 4, 5, g);

    held = enc_r(6'd0, 3, 5, 8);
    x = enc_r(6'd0, 3, 5, 9);
    cycle(0, 1, held, 1, 0, 0, 0, g);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, x, 0, 0, 0, 0, g);
      chk("bp_ready", {31'd0, g}, 0);
      chk("bp_hold", ir, held);
    end
    cycle(0, 1, x, 1, 0, 0, 0, g);
    chk("bp_next", ir, x);
    cycle(0, 0, 0, 1, 0, 0, 0, g);
    chk("bp_drain", {31'd0, out_valid}, 0);
    cycle(0, 0, 0, 1, 1, 8, 1, g);
    cycle(0, 0, 0, 1, 1, 9, 2, g);

    cycle(0, 1, enc_r(6'h3F, 3, 5, 10), 1, 0, 0, 0, g);
    chk("ill_id", ID, 0);
    chk("ill_flag", {31'd0, illegal}, 1);
    chk("ill_wr", {31'd0, wr_en}, 0);
    cycle(0, 1, enc_r(6'd0, 10, 10, 11), 1, 0, 0, 0, g);
    chk("ill_no_sb", {31'd0, g}, 1);
    cycle(0, 0, 0, 1, 1, 11, 0, g);

    cycle(0, 1, enc_r(6'd0, 3, 5, 1), 0, 0, 0, 0, g);
    cycle(1, 1, enc_r(6'd0, 3, 5, 2), 0, 0, 0, 0, g);
    chk("rst_drop", {31'd0, out_valid}, 0);
    cycle(0, 1, enc_r(6'd0, 1, 3, 2), 1, 0, 0, 0, g);
    chk("rst_sb_clear", {31'd0, g}, 1);
    chk("rst_rf_rs", rs, 0);
    chk("rst_rf_rt", rt, 0);

    for (int k = 0; k < 400; k++) begin
      x = $urandom;
      x[31:26] = ops[$urandom_range(0, 9)];
      x[25:21] = 5'($urandom_range(0, 7));
      x[20:16] = 5'($urandom_range(0, 7));
      x[15:11] = 5'($urandom_range(0, 7));
      cycle(0, $urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            $urandom, g);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have port in_valid  in  1  fetch presents in_ir.
REQ-003 SHALL have port in_ready  out  1  stage accepts in_ir this cycle.
REQ-004 SHALL have port in_ir  in  32  fetched instruction.
REQ-005 SHALL have port wb_en  in  1  writeback strobe.
REQ-006 SHALL have port wb_addr  in  5  writeback register.
REQ-007 SHALL have port wb_data  in  32  writeback value.
REQ-008 SHALL have port out_valid  out  1  issued bundle valid.
REQ-009 SHALL have port out_ready  in  1  ALU stage consumes bundle.
REQ-010 SHALL have ports ir  out  32  issued instruction; ID  out  32  decoded ID; rs  out  32  operand 1; rt  out  32  operand 2 (register or immediate); sd  out  32  store data; dest  out  5  destination register; wr_en  out  1  result written back; illegal  out  1  unknown opcode.

Function
REQ-011 SHALL decode opcode in_ir[31:26]: 000000->ID 1 (add), 000001->2 (subi), 000011->7 (and), 000110->10 (ori), 001000->13 (lw), 001001->14 (sw), 010000->21 (j), 010011->24 (slt); any other opcode->ID 0 with illegal=1, wr_en=0.
REQ-012 SHALL read rs = RF[in_ir[25:21]] for all IDs except 21 (rs=0).
REQ-013 R-type (IDs 1,7,24): rt = RF[in_ir[20:16]], dest = in_ir[15:11], wr_en=1.
REQ-014 IDs 2,13: rt = sign-extended in_ir[15:0]; ID 10: rt = zero-extended in_ir[15:0]; dest = in_ir[20:16]; wr_en=1.
REQ-015 ID 14: rt = sign-extended in_ir[15:0], sd = RF[in_ir[20:16]], wr_en=0; ID 21: rt = zero-extended in_ir[25:0], wr_en=0; sd=0 for all IDs except 14.
REQ-016 dest=0 SHALL force wr_en=0; RF[0] SHALL always read 0 and ignore writes.
REQ-017 Register read SHALL see same-cycle writeback (wb_en with matching wb_addr returns wb_data).
REQ-018 Accept: transfer occurs when in_valid && in_ready; bundle SHALL appear on outputs with out_valid=1 on the next cycle (latency 1).
REQ-019 Outputs SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear after a transfer with no new accept.
REQ-020 in_ready = (!out_valid || out_ready) && !hazard; full throughput of one bundle per cycle with no hazard.
REQ-021 Scoreboard: 32 pending bits; bit[dest] SHALL set on accept of a bundle with wr_en=1; bit[wb_addr] SHALL clear on wb_en.
REQ-022 hazard SHALL be 1 when in_valid and any used source (rs field except ID 21; rt field for IDs 1,7,24,14) or the dest of a wr_en instruction has its pending bit set, unless that bit is cleared by wb_en this same cycle.
REQ-023 Same-cycle set and clear of the same bit: set SHALL win.
REQ-024 Illegal instructions SHALL still issue (illegal=1, no scoreboard update).

Reset
REQ-025 Reset SHALL clear out_valid, ir, ID, rs, rt, sd, dest, wr_en, illegal to 0, all scoreboard bits, and all 32 registers, on the first rising clk edge with reset=1.
REQ-026 in_ready SHALL be 0 while reset=1; a bundle pending at reset SHALL be discarded.

Structure
REQ-027 Opcode constants, ID constants, and field bit positions SHALL live in a shared package used by this block and alu_top.
REQ-028 The register file SHALL be a sub-module reg_file (32x32, two read ports, one write port, write bypass).

Verification
REQ-029 Reset, then wb x3=10, x5=12; issue 0x00653000 (add $6,$3,$5) -> next cycle out_valid=1, ID=1, rs=10, rt=12, dest=6, wr_en=1.
REQ-030 x2=10; issue subi $1,$2,-1 (imm 0xFFFF) -> ID=2, rs=10, rt=0xFFFFFFFF; ori imm 0xFFFF -> ID=10, rt=0x0000FFFF.
REQ-031 Issue add $1,$3,$5 then and $4,$1,$3 -> in_ready=0 until wb_en addr 1; stall ends same cycle as the writeback, rs=wb_data.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no instruction lost or duplicated.
REQ-033 Issue opcode 111111 -> ID=0, illegal=1, wr_en=0, scoreboard unchanged.
REQ-034 Assert reset with out_valid=1 and pending bit 1 set -> next cycle out_valid=0, scoreboard clear, RF reads 0.
